jet_result_collector: RTL and testbench
=======================================

// Module: jet_result_collector
// PURPOSE
//  Receiving end of the HLS core's output interface: captures the N_OUT per-lane output
//  words (each with its own ap_vld strobe) into one result frame. Computes a signed argmax
//  (predicted jet class), then presents the frame downstream on a valid/ready handshake.
//  Sits between the jet-tagging core outputs (layer16_out_*) and the result sink/logger.
// PARAMETERS
//  N_OUT    5   number of output lanes (classes)
//  WIDTH    16  lane word width, signed fixed point
//  NFRAC    10  fractional bits (documentation/bench scaling only; no arithmetic use)
//  CLASS_W  3   width of class index, >= clog2(N_OUT)
//  CNT_W    32  width of frame/drop counters
// PORTS
//  ap_clk        in   1              clock, all logic on rising edge
//  ap_rst_n      in   1              synchronous active-low reset
//  ap_done       in   1              core done pulse (frame boundary)
//  lane_data     in   N_OUT*WIDTH    lane i at [i*WIDTH +: WIDTH], signed
//  lane_vld      in   N_OUT          lane i strobe (core layer16_out_i_ap_vld)
//  res_data      out  N_OUT*WIDTH    captured frame, same packing as lane_data
//  res_class     out  CLASS_W        index of max lane
//  res_max       out  WIDTH          value of max lane
//  res_valid     out  1              frame available
//  res_ready     in   1              downstream accepts when res_valid&res_ready
//  frame_cnt     out  CNT_W          frames accepted downstream
//  drop_cnt      out  CNT_W          lane strobes discarded while busy
//  incomplete    out  1              sticky: ap_done seen with lanes missing
// BEHAVIOUR
//  Reset (ap_rst_n=0 at edge): state=COLLECT, mask=0, res_* = 0, res_valid=0,
//   frame_cnt=drop_cnt=0, incomplete=0. Reset mid-frame abandons the frame, no output.
//  FSM COLLECT -> ARGMAX -> HOLD -> COLLECT.
//  COLLECT: per lane, lane_vld[i]=1 registers lane_data[i] and sets mask[i].
//   A repeat strobe on an already-set lane overwrites the value (last one wins).
//   If (mask | lane_vld) == all-ones at an edge -> ARGMAX next cycle, idx=0.
//   If ap_done=1 and (mask | lane_vld) != all-ones -> set incomplete, clear mask,
//    stay COLLECT. ap_done is otherwise ignored; frame completion is strobe-driven.
//  ARGMAX: one lane per cycle, N_OUT cycles. idx=0 loads best=lane0, class=0.
//   For idx 1..N_OUT-1: if lane[idx] > best (signed, strict) then best=lane[idx],
//   class=idx. Ties keep the lower index. After idx=N_OUT-1 -> HOLD.
//  HOLD: res_valid=1; res_data/res_class/res_max stable until the handshake.
//   On res_valid&res_ready: frame_cnt+1, mask=0, res_valid=0 next cycle, -> COLLECT.
//  Latency: last strobe at edge T -> res_valid=1 from edge T+N_OUT+1.
//   Earliest re-accept in COLLECT is the edge after the handshake.
//  Busy (ARGMAX/HOLD): lane strobes are not captured. drop_cnt += popcount(lane_vld)
//   per cycle. ap_done is ignored.
//  Counters wrap modulo 2^CNT_W. incomplete is cleared only by reset.
//  res_data is a registered copy of the capture regs. It is updated only on ARGMAX
//   entry, so it holds the last frame while COLLECT gathers the next.
// TESTING
//  1 All 5 strobes same cycle: 0x0100,0x0C00,0xFC00,0x0400,0x0000 -> res_class=1,
//    res_max=0x0C00, res_valid exactly 6 cycles later.
//  2 Staggered strobes lanes 4,0,2,1,3 over 5 cycles, all negative (0x8000..), lane2=0xFFFF
//    -> class=2. Latency is counted from the lane3 strobe.
//  3 Tie: lanes 1 and 3 both 0x0400, others 0 -> class=1. Hold res_ready=0 for 10 cycles
//    -> outputs stable, res_valid held. Then ready=1 -> frame_cnt=1.
//  4 ap_done with only lanes 0-3 strobed -> incomplete=1, no res_valid.
//    Next full frame is then captured normally.
//  5 Strobe all 5 lanes during HOLD -> drop_cnt=5, res_data unchanged.
//  6 Drop ap_rst_n mid-ARGMAX -> next cycle res_valid=0, counters=0, state COLLECT.
//    Back-to-back frames afterwards are all delivered, frame_cnt matches.

Source files
------------

// File: rtl/jet_result_collector_if.sv
// Bundle between the jet-tagging core output lanes, the result collector and the result sink.
// The collector takes the slave modport; the core/sink side takes the master modport.
interface jet_result_collector_if #(
  parameter int N_OUT   = 5,
  parameter int WIDTH   = 16,
  parameter int CLASS_W = 3,
  parameter int CNT_W   = 32
);
  logic                     ap_done;
  logic [N_OUT*WIDTH-1:0]   lane_data;
  logic [N_OUT-1:0]         lane_vld;
  logic [N_OUT*WIDTH-1:0]   res_data;
  logic [CLASS_W-1:0]       res_class;
  logic [WIDTH-1:0]         res_max;
  logic                     res_valid;
  logic                     res_ready;
  logic [CNT_W-1:0]         frame_cnt;
  logic [CNT_W-1:0]         drop_cnt;
  logic                     incomplete;

  modport master (
    output ap_done, lane_data, lane_vld, res_ready,
    input  res_data, res_class, res_max, res_valid, frame_cnt, drop_cnt, incomplete
  );

  modport slave (
    input  ap_done, lane_data, lane_vld, res_ready,
    output res_data, res_class, res_max, res_valid, frame_cnt, drop_cnt, incomplete
  );
endinterface

// File: rtl/jet_result_collector.sv
// Captures the per-lane outputs of the jet-tagging core into one frame, finds the signed
// argmax over N_OUT cycles and presents the frame downstream on a valid/ready handshake.
module jet_result_collector #(
  parameter int N_OUT   = 5,
  parameter int WIDTH   = 16,
  parameter int NFRAC   = 10,
  parameter int CLASS_W = 3,
  parameter int CNT_W   = 32
) (
  input  logic ap_clk,
  input  logic ap_rst_n,
  jet_result_collector_if.slave bus
);

  localparam int IDX_W = $clog2(N_OUT + 1);

  if (NFRAC >= WIDTH || CLASS_W < $clog2(N_OUT)) begin : g_param_check
    $error("jet_result_collector: NFRAC must be < WIDTH and CLASS_W >= clog2(N_OUT)");
  end

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ARGMAX  = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t                    state, state_nxt;
  logic [N_OUT-1:0]          mask;
  logic [N_OUT-1:0]          seen;
  logic                      full;
  logic signed [WIDTH-1:0]   cap   [N_OUT];
  logic signed [WIDTH-1:0]   frame [N_OUT];
  logic [IDX_W-1:0]          idx;
  logic signed [WIDTH-1:0]   cur;
  logic signed [WIDTH-1:0]   best;
  logic [CLASS_W-1:0]        best_class;
  logic [CLASS_W-1:0]        class_q;
  logic [WIDTH-1:0]          max_q;
  logic                      valid_q;
  logic [CNT_W-1:0]          frame_cnt_q;
  logic [CNT_W-1:0]          drop_cnt_q;
  logic                      incomplete_q;
  logic [CNT_W-1:0]          vld_pop;

  assign seen = mask | bus.lane_vld;
  assign full = &seen;

  assign bus.res_class  = class_q;
  assign bus.res_max    = max_q;
  assign bus.res_valid  = valid_q;
  assign bus.frame_cnt  = frame_cnt_q;
  assign bus.drop_cnt   = drop_cnt_q;
  assign bus.incomplete = incomplete_q;

  always_comb begin
    bus.res_data = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      bus.res_data[i*WIDTH +: WIDTH] = frame[i];
    end
  end

  always_comb begin
    cur = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      if (idx == IDX_W'(i)) cur = frame[i];
    end
  end

  always_comb begin
    vld_pop = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      vld_pop = vld_pop + CNT_W'(bus.lane_vld[i]);
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) state <= COLLECT;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      COLLECT: if (full) state_nxt = ARGMAX;
      ARGMAX:  if (idx == IDX_W'(N_OUT)) state_nxt = HOLD;
      HOLD:    if (valid_q && bus.res_ready) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  // ARGMAX walks idx 0..N_OUT-1 comparing, then spends idx==N_OUT publishing the result,
  // which sets the completing-strobe-to-valid latency at N_OUT+1 cycles.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      mask         <= '0;
      idx          <= '0;
      best         <= '0;
      best_class   <= '0;
      class_q      <= '0;
      max_q        <= '0;
      valid_q      <= 1'b0;
      frame_cnt_q  <= '0;
      drop_cnt_q   <= '0;
      incomplete_q <= 1'b0;
      for (int unsigned i = 0; i < N_OUT; i++) begin
        cap[i]   <= '0;
        frame[i] <= '0;
      end
    end else begin
      unique case (state)
        COLLECT: begin
          for (int unsigned i = 0; i < N_OUT; i++) begin
            if (bus.lane_vld[i]) cap[i] <= bus.lane_data[i*WIDTH +: WIDTH];
          end
          if (full) begin
            mask <= seen;
            idx  <= '0;
            // Frame snapshot includes strobes arriving on the completing edge.
            for (int unsigned i = 0; i < N_OUT; i++) begin
              frame[i] <= bus.lane_vld[i] ? bus.lane_data[i*WIDTH +: WIDTH] : cap[i];
            end
          end else if (bus.ap_done) begin
            incomplete_q <= 1'b1;
            mask         <= '0;
          end else begin
            mask <= seen;
          end
        end
        ARGMAX: begin
          drop_cnt_q <= drop_cnt_q + vld_pop;
          idx        <= idx + 1'b1;
          if (idx == IDX_W'(N_OUT)) begin
            class_q <= best_class;
            max_q   <= best;
            valid_q <= 1'b1;
          end else if (idx == '0 || cur > best) begin
            best       <= cur;
            best_class <= CLASS_W'(idx);
          end
        end
        HOLD: begin
          drop_cnt_q <= drop_cnt_q + vld_pop;
          if (valid_q && bus.res_ready) begin
            valid_q     <= 1'b0;
            frame_cnt_q <= frame_cnt_q + 1'b1;
            mask        <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jet_result_collector.sv
// Randomized self-checking bench for jet_result_collector against a plain argmax model.
module tb_jet_result_collector;

  typedef logic signed [15:0] lane_t;
  typedef lane_t frame_t [5];

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   exp_frames;
  int   exp_drops;
  logic exp_incomplete;

  jet_result_collector_if #(.N_OUT(5), .WIDTH(16), .CLASS_W(3), .CNT_W(32)) bus ();

  jet_result_collector #(
    .N_OUT(5), .WIDTH(16), .NFRAC(10), .CLASS_W(3), .CNT_W(32)
  ) dut (
    .ap_clk  (clk),
    .ap_rst_n(rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic lane_t rand_val();
    case ($urandom_range(0, 7))
      0: return 16'h0400;
      1: return 16'hFC00;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'h0000;
      default: return lane_t'($urandom);
    endcase
  endfunction

  function automatic logic [79:0] pack(input frame_t v);
    logic [79:0] p;
    for (int i = 0; i < 5; i++) p[i*16 +: 16] = v[i];
    return p;
  endfunction

  // Reference: maximum value first, then the lowest lane holding it.
  task automatic ref_argmax(input frame_t v, output int cls, output lane_t mx);
    mx = v[0];
    for (int i = 1; i < 5; i++) if (v[i] > mx) mx = v[i];
    cls = -1;
    for (int i = 4; i >= 0; i--) if (v[i] == mx) cls = i;
  endtask

  task automatic drive_cycle(input logic [4:0] vld, input frame_t v, input logic done);
    for (int i = 0; i < 5; i++) bus.lane_data[i*16 +: 16] = vld[i] ? v[i] : 16'($urandom);
    bus.lane_vld = vld;
    bus.ap_done  = done;
    tick();
    bus.lane_vld  = '0;
    bus.ap_done   = 1'b0;
    bus.lane_data = 80'($urandom);
  endtask

  task automatic send_ordered(input frame_t v, input int order [5]);
    logic [4:0] one;
    one = 5'd1;
    for (int k = 0; k < 5; k++) drive_cycle(one << order[k], v, 1'b0);
  endtask

  // Random grouping with repeats; last strobe per lane wins; returns at the completing edge.
  task automatic send_random(output frame_t fin);
    logic [4:0] seen_l, vld;
    logic       done;
    frame_t     v;
    int         c;
    seen_l = '0;
    c = 0;
    while (seen_l != 5'h1F) begin
      vld = 5'($urandom);
      if (c >= 3) vld = vld | ~seen_l;
      for (int i = 0; i < 5; i++) v[i] = rand_val();
      for (int i = 0; i < 5; i++) if (vld[i]) fin[i] = v[i];
      done = ((seen_l | vld) == 5'h1F) ? 1'($urandom_range(0, 1)) : 1'b0;
      drive_cycle(vld, v, done);
      seen_l = seen_l | vld;
      c++;
    end
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (bus.res_valid !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic accept();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    exp_frames++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.res_data !== '0 || bus.res_class !== '0 || bus.res_max !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%h class=%0d max=%h required 0", bus.res_valid, bus.res_data, bus.res_class, bus.res_max);
    end
    checks++;
    if (bus.frame_cnt !== 32'd0 || bus.drop_cnt !== 32'd0 || bus.incomplete !== 1'b0) begin
      errors++;
      $display("FAIL reset_counters: frame=%0d drop=%0d incomplete=%b required 0", bus.frame_cnt, bus.drop_cnt, bus.incomplete);
    end
  endtask

  task automatic test_all_same_cycle();
    frame_t v;
    int cyc, cls;
    lane_t mx;
    v = '{16'h0100, 16'h0C00, 16'hFC00, 16'h0400, 16'h0000};
    ref_argmax(v, cls, mx);
    drive_cycle(5'h1F, v, 1'b0);
    wait_valid(cyc);
    checks++;
    if (cyc != 6) begin errors++; $display("FAIL t1_latency: got %0d cycles required 6", cyc); end
    checks++;
    if (bus.res_class !== 3'(cls) || bus.res_max !== 16'(mx)) begin
      errors++;
      $display("FAIL t1_argmax: class=%0d max=%h required class=%0d max=%h", bus.res_class, bus.res_max, cls, mx);
    end
    checks++;
    if (bus.res_data !== pack(v)) begin errors++; $display("FAIL t1_data: got %h required %h", bus.res_data, pack(v)); end
    accept();
    checks++;
    if (bus.res_valid !== 1'b0 || bus.frame_cnt !== 32'(exp_frames)) begin
      errors++;
      $display("FAIL t1_accept: valid=%b frame_cnt=%0d required 0/%0d", bus.res_valid, bus.frame_cnt, exp_frames);
    end
  endtask

  task automatic test_staggered_negative();
    frame_t v;
    int order [5];
    int cyc, cls;
    lane_t mx;
    v = '{16'h8000, 16'h8001, 16'hFFFF, 16'h9000, 16'h8123};
    order = '{4, 0, 2, 1, 3};
    ref_argmax(v, cls, mx);
    send_ordered(v, order);
    wait_valid(cyc);
    checks++;
    if (cyc != 6) begin errors++; $display("FAIL t2_latency: got %0d cycles required 6", cyc); end
    checks++;
    if (bus.res_class !== 3'(cls) || bus.res_max !== 16'(mx)) begin
      errors++;
      $display("FAIL t2_argmax: class=%0d max=%h required class=%0d max=%h", bus.res_class, bus.res_max, cls, mx);
    end
    accept();
  endtask

  task automatic test_tie_and_hold();
    frame_t v;
    int order [5];
    int cyc, cls;
    lane_t mx;
    v = '{16'h0000, 16'h0400, 16'h0000, 16'h0400, 16'h0000};
    order = '{3, 1, 0, 4, 2};
    ref_argmax(v, cls, mx);
    send_ordered(v, order);
    wait_valid(cyc);
    checks++;
    if (bus.res_class !== 3'(cls) || bus.res_max !== 16'(mx)) begin
      errors++;
      $display("FAIL t3_tie: class=%0d max=%h required class=%0d max=%h", bus.res_class, bus.res_max, cls, mx);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== pack(v) || bus.res_class !== 3'(cls)) begin
        errors++;
        $display("FAIL t3_hold[%0d]: valid=%b data=%h class=%0d", k, bus.res_valid, bus.res_data, bus.res_class);
      end
    end
    accept();
    checks++;
    if (bus.frame_cnt !== 32'(exp_frames)) begin
      errors++;
      $display("FAIL t3_frame_cnt: got %0d required %0d", bus.frame_cnt, exp_frames);
    end
  endtask

  task automatic test_incomplete();
    frame_t v, f;
    int order [4];
    int cyc, cls;
    logic [4:0] one;
    logic seen_valid;
    lane_t mx;
    one = 5'd1;
    for (int i = 0; i < 5; i++) v[i] = rand_val();
    order = '{2, 0, 3, 1};
    for (int k = 0; k < 4; k++) drive_cycle(one << order[k], v, 1'b0);
    drive_cycle(5'h00, v, 1'b1);
    exp_incomplete = 1'b1;
    checks++;
    if (bus.incomplete !== 1'b1) begin errors++; $display("FAIL t4_incomplete: got %b required 1", bus.incomplete); end
    seen_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.res_valid !== 1'b0) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid !== 1'b0) begin errors++; $display("FAIL t4_no_valid: res_valid asserted, required 0"); end
    send_random(f);
    ref_argmax(f, cls, mx);
    wait_valid(cyc);
    checks++;
    if (cyc != 6 || bus.res_data !== pack(f) || bus.res_class !== 3'(cls)) begin
      errors++;
      $display("FAIL t4_next_frame: cyc=%0d class=%0d data=%h required 6/%0d/%h", cyc, bus.res_class, bus.res_data, cls, pack(f));
    end
    accept();
  endtask

  task automatic test_busy_drops();
    frame_t v, junk;
    logic [4:0] vld;
    int cyc, cls;
    lane_t mx;
    for (int i = 0; i < 5; i++) v[i] = rand_val();
    ref_argmax(v, cls, mx);
    drive_cycle(5'h1F, v, 1'b0);
    for (int k = 0; k < 3; k++) begin
      vld = 5'($urandom);
      for (int i = 0; i < 5; i++) junk[i] = rand_val();
      drive_cycle(vld, junk, 1'b0);
      exp_drops += $countones(vld);
    end
    wait_valid(cyc);
    checks++;
    if (cyc != 3) begin errors++; $display("FAIL t5_latency: got %0d more cycles required 3", cyc); end
    for (int i = 0; i < 5; i++) junk[i] = ~v[i];
    drive_cycle(5'h1F, junk, 1'b1);
    exp_drops += 5;
    checks++;
    if (bus.drop_cnt !== 32'(exp_drops)) begin
      errors++;
      $display("FAIL t5_drop_cnt: got %0d required %0d", bus.drop_cnt, exp_drops);
    end
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== pack(v) || bus.res_class !== 3'(cls) || bus.res_max !== 16'(mx)) begin
      errors++;
      $display("FAIL t5_frame_kept: valid=%b data=%h class=%0d required 1/%h/%0d", bus.res_valid, bus.res_data, bus.res_class, pack(v), cls);
    end
    accept();
  endtask

  task automatic test_reset_mid_argmax();
    frame_t f;
    logic seen_valid;
    send_random(f);
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_frames = 0;
    exp_drops = 0;
    exp_incomplete = 1'b0;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.frame_cnt !== 32'd0 || bus.drop_cnt !== 32'd0 || bus.incomplete !== 1'b0) begin
      errors++;
      $display("FAIL t6_reset: valid=%b frame=%0d drop=%0d incomplete=%b required 0", bus.res_valid, bus.frame_cnt, bus.drop_cnt, bus.incomplete);
    end
    seen_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.res_valid !== 1'b0) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid !== 1'b0) begin errors++; $display("FAIL t6_abandoned: res_valid asserted after reset"); end
  endtask

  task automatic test_back_to_back();
    frame_t f;
    int cyc, cls;
    lane_t mx;
    bus.res_ready = 1'b1;
    for (int n = 0; n < 25; n++) begin
      send_random(f);
      ref_argmax(f, cls, mx);
      wait_valid(cyc);
      checks++;
      if (cyc != 6 || bus.res_class !== 3'(cls) || bus.res_max !== 16'(mx) || bus.res_data !== pack(f)) begin
        errors++;
        $display("FAIL b2b_frame[%0d]: cyc=%0d class=%0d max=%h data=%h required 6/%0d/%h/%h", n, cyc, bus.res_class, bus.res_max, bus.res_data, cls, mx, pack(f));
      end
      tick();
      exp_frames++;
      checks++;
      if (bus.res_valid !== 1'b0 || bus.frame_cnt !== 32'(exp_frames)) begin
        errors++;
        $display("FAIL b2b_accept[%0d]: valid=%b frame_cnt=%0d required 0/%0d", n, bus.res_valid, bus.frame_cnt, exp_frames);
      end
    end
    bus.res_ready = 1'b0;
    checks++;
    if (bus.drop_cnt !== 32'(exp_drops) || bus.incomplete !== exp_incomplete) begin
      errors++;
      $display("FAIL b2b_status: drop=%0d incomplete=%b required %0d/%b", bus.drop_cnt, bus.incomplete, exp_drops, exp_incomplete);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_frames = 0;
    exp_drops = 0;
    exp_incomplete = 1'b0;
    rst_n = 1'b0;
    bus.ap_done = 1'b0;
    bus.lane_vld = '0;
    bus.lane_data = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_all_same_cycle();
    test_staggered_negative();
    test_tie_and_hold();
    test_incomplete();
    test_busy_drops();
    test_reset_mid_argmax();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
